mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle main controller for the 32-bit MIPS datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives datapath mux selects, write enables and the 3-bit ALUop consumed by alu_control.
- Handshakes with instruction/data memory through a ready signal so memory stalls hold the current state.
- Counts retired instructions for debug.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous reset, active low
- opcode  input  6  instr[31:26] from instruction register
- mem_ready  input  1  memory access completes this cycle
- ir_write  output  1  load instruction register
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- iord  output  1  0=PC address, 1=ALUOut address
- pc_write  output  1  unconditional PC update
- branch_eq  output  1  PC update if ALU zero
- branch_ne  output  1  PC update if not zero
- pc_src  output  2  00=ALU, 01=ALUOut, 10=jump target
- alu_src_a  output  1  0=PC, 1=regA
- alu_src_b  output  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
- alu_op  output  3  to alu_control
- reg_write  output  1  register file write
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=MDR
- illegal  output  1  one-cycle pulse on unknown opcode
- state  output  4  current state, debug
- retired  output  CNT_W  retired instruction count

Behaviour:
- Reset: a synchronous reset_n=0 at a rising edge sets state=FETCH(0), retired=0 and illegal=0. This overrides any in-flight access; no write strobe is issued after reset.
- Moore outputs decode combinationally from state. Unlisted outputs are 0 in every state.
- alu_op encoding: 000 add, 001 sub, 010 R-type (funct decides), 011 and, 100 or, 101 slt.
- FETCH(0):
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_write=1 and pc_write=1 only when mem_ready=1; otherwise hold in FETCH.
  - Next: DECODE when mem_ready=1.
- DECODE(1):
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target).
  - Next by opcode: 000000→EXEC; 100011/101011→MEMADR; 000100/000101→BRANCH; 000010→JUMP; 001000/001100/001101/001010→IEXEC.
  - Any other opcode → FETCH with illegal=1 registered for exactly one cycle; retired is not incremented.
- MEMADR(2):
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=000.
  - Next: MEMRD if lw, MEMWR if sw.
- MEMRD(3):
  - Outputs: mem_read=1, iord=1.
  - Hold while mem_ready=0; then MEMWB.
- MEMWB(4):
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next: FETCH.
- MEMWR(5):
  - Outputs: mem_write=1, iord=1.
  - Hold while mem_ready=0; then FETCH. mem_write stays asserted the whole wait.
- EXEC(6):
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=010.
  - Next: ALUWB.
- ALUWB(7):
  - Outputs: reg_write=1, reg_dst=1.
  - Next: FETCH.
- BRANCH(8):
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01.
  - branch_eq=1 for beq; branch_ne=1 for bne.
  - Next: FETCH.
- IEXEC(9):
  - Outputs: alu_src_a=1, alu_src_b=10.
  - alu_op: 000 addi, 011 andi, 100 ori, 101 slti.
  - Next: IWB.
- IWB(10):
  - Outputs: reg_write=1, reg_dst=0.
  - Next: FETCH.
- JUMP(11):
  - Outputs: pc_write=1, pc_src=10.
  - Next: FETCH.
- opcode sampling: opcode is read in DECODE and in every later state. It must remain stable because the IR is only written in FETCH.
- retired counter:
  - Increments by 1 on the transition from each last state (MEMWB, MEMWR with mem_ready, ALUWB, BRANCH, IWB, JUMP) back to FETCH.
  - Wraps from all-ones to 0 without a flag.
- Unused state encodings 12–15 go to FETCH on the next edge, with illegal=1 for one cycle.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.

Test Plan:
- Hold reset_n=0 for 3 cycles with mem_ready=1, then release → state=0, retired=0, and mem_read=1 in FETCH immediately.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; retired=1.
- R-type (000000), then addi (001000) → alu_op=010 in EXEC with reg_dst=1 in ALUWB; alu_op=000 in IEXEC with reg_dst=0 in IWB; retired=2 after 8 cycles.
- sw with mem_ready=0 for 3 cycles in MEMWR → mem_write held high for 4 cycles, then FETCH; FETCH stall with mem_ready=0 keeps ir_write=0 and pc_write=0.
- Opcode 111111 → DECODE→FETCH, illegal pulses 1 cycle, retired unchanged. beq → alu_op=001, branch_eq=1 for 1 cycle.
- Assert reset_n=0 during MEMRD stall → next state 0 with no reg_write. Preload retired to all-ones via a j sequence → wraps to 0.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller and the MIPS datapath/memory.
// The master side (controller) drives selects, strobes and debug outputs.
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             pc_write;
    logic             branch_eq;
    logic             branch_ne;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output ir_write, mem_read, mem_write, iord, pc_write, branch_eq, branch_ne, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, state,
               retired
    );

    modport slave (
        output opcode, mem_ready,
        input  ir_write, mem_read, mem_write, iord, pc_write, branch_eq, branch_ne, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, state,
               retired
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore decode of datapath controls from state,
// memory-ready stalls, one-cycle illegal pulse and a wrapping retired-instruction counter.
module mc_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input logic               clk,
    input logic               reset_n,
    mc_control_fsm_if.master  ctrl_io
);
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StIExec  = 4'd9,
        StIWb    = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            StFetch:  if (ctrl_io.mem_ready) state_d = StDecode;
            StDecode: begin
                case (ctrl_io.opcode)
                    OpRType:                        state_d = StExec;
                    OpLw, OpSw:                     state_d = StMemAdr;
                    OpBeq, OpBne:                   state_d = StBranch;
                    OpJ:                            state_d = StJump;
                    OpAddi, OpAndi, OpOri, OpSlti:  state_d = StIExec;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (ctrl_io.opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (ctrl_io.mem_ready) state_d = StMemWb;
            StMemWr: begin
                if (ctrl_io.mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExec:   state_d = StAluWb;
            StIExec:  state_d = StIWb;
            StMemWb, StAluWb, StBranch, StIWb, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: begin
                // Unused encodings recover to fetch and flag it.
                state_d   = StFetch;
                illegal_d = 1'b1;
            end
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        ctrl_io.ir_write   = 1'b0;
        ctrl_io.mem_read   = 1'b0;
        ctrl_io.mem_write  = 1'b0;
        ctrl_io.iord       = 1'b0;
        ctrl_io.pc_write   = 1'b0;
        ctrl_io.branch_eq  = 1'b0;
        ctrl_io.branch_ne  = 1'b0;
        ctrl_io.pc_src     = 2'b00;
        ctrl_io.alu_src_a  = 1'b0;
        ctrl_io.alu_src_b  = 2'b00;
        ctrl_io.alu_op     = 3'b000;
        ctrl_io.reg_write  = 1'b0;
        ctrl_io.reg_dst    = 1'b0;
        ctrl_io.mem_to_reg = 1'b0;
        case (state_q)
            StFetch: begin
                ctrl_io.mem_read  = 1'b1;
                ctrl_io.alu_src_b = 2'b01;
                ctrl_io.ir_write  = ctrl_io.mem_ready;
                ctrl_io.pc_write  = ctrl_io.mem_ready;
            end
            StDecode: ctrl_io.alu_src_b = 2'b11;
            StMemAdr: begin
                ctrl_io.alu_src_a = 1'b1;
                ctrl_io.alu_src_b = 2'b10;
            end
            StMemRd: begin
                ctrl_io.mem_read = 1'b1;
                ctrl_io.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl_io.reg_write  = 1'b1;
                ctrl_io.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl_io.mem_write = 1'b1;
                ctrl_io.iord      = 1'b1;
            end
            StExec: begin
                ctrl_io.alu_src_a = 1'b1;
                ctrl_io.alu_op    = 3'b010;
            end
            StAluWb: begin
                ctrl_io.reg_write = 1'b1;
                ctrl_io.reg_dst   = 1'b1;
            end
            StBranch: begin
                ctrl_io.alu_src_a = 1'b1;
                ctrl_io.alu_op    = 3'b001;
                ctrl_io.pc_src    = 2'b01;
                ctrl_io.branch_eq = (ctrl_io.opcode == OpBeq);
                ctrl_io.branch_ne = (ctrl_io.opcode == OpBne);
            end
            StIExec: begin
                ctrl_io.alu_src_a = 1'b1;
                ctrl_io.alu_src_b = 2'b10;
                case (ctrl_io.opcode)
                    OpAndi:  ctrl_io.alu_op = 3'b011;
                    OpOri:   ctrl_io.alu_op = 3'b100;
                    OpSlti:  ctrl_io.alu_op = 3'b101;
                    default: ctrl_io.alu_op = 3'b000;
                endcase
            end
            StIWb: ctrl_io.reg_write = 1'b1;
            StJump: begin
                ctrl_io.pc_write = 1'b1;
                ctrl_io.pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

    assign ctrl_io.state   = state_q;
    assign ctrl_io.illegal = illegal_q;
    assign ctrl_io.retired = retired_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; a narrow counter keeps the wrap test short.
module tb_mc_control_fsm;
    localparam int unsigned CntW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_ret = 0;

    mc_control_fsm_if #(.CNT_W(CntW)) ctrl_if ();

    mc_control_fsm #(.CNT_W(CntW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl_io (ctrl_if.master)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        ctrl_if.mem_ready = 1'b1;
        ctrl_if.opcode    = 6'b000000;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        n_cmp++; if (ctrl_if.state !== 4'd0) begin n_bad++;
            $display("FAIL reset_state: got %0d want 0", ctrl_if.state); end
        n_cmp++; if (ctrl_if.retired !== 4'd0) begin n_bad++;
            $display("FAIL reset_retired: got %0d want 0", ctrl_if.retired); end
        n_cmp++; if (ctrl_if.mem_read !== 1'b1) begin n_bad++;
            $display("FAIL reset_mem_read: got %b want 1", ctrl_if.mem_read); end
        n_cmp++; if (ctrl_if.illegal !== 1'b0) begin n_bad++;
            $display("FAIL reset_illegal: got %b want 0", ctrl_if.illegal); end
        exp_ret = 0;
    endtask

    task automatic test_lw();
        int seq [5] = '{0, 1, 2, 3, 4};
        ctrl_if.opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ctrl_if.state !== 4'(seq[i])) begin n_bad++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, ctrl_if.state, seq[i]); end
            n_cmp++; if (ctrl_if.reg_write !== (seq[i] == 4) ||
                         ctrl_if.mem_to_reg !== (seq[i] == 4)) begin n_bad++;
                $display("FAIL lw_wb[%0d]: got rw=%b m2r=%b want %b", i, ctrl_if.reg_write,
                         ctrl_if.mem_to_reg, seq[i] == 4); end
            tick();
        end
        exp_ret++;
        n_cmp++; if (ctrl_if.state !== 4'd0 || ctrl_if.retired !== 4'(exp_ret)) begin n_bad++;
            $display("FAIL lw_end: got st=%0d ret=%0d want st=0 ret=%0d", ctrl_if.state,
                     ctrl_if.retired, exp_ret); end
    endtask

    task automatic test_rtype_addi();
        int seq [8] = '{0, 1, 6, 7, 0, 1, 9, 10};
        for (int i = 0; i < 8; i++) begin
            if (i == 0) ctrl_if.opcode = 6'b000000;
            if (i == 4) ctrl_if.opcode = 6'b001000;
            n_cmp++; if (ctrl_if.state !== 4'(seq[i])) begin n_bad++;
                $display("FAIL ri_state[%0d]: got %0d want %0d", i, ctrl_if.state, seq[i]); end
            if (i == 2) begin
                n_cmp++; if (ctrl_if.alu_op !== 3'b010) begin n_bad++;
                    $display("FAIL exec_alu_op: got %b want 010", ctrl_if.alu_op); end
            end
            if (i == 3) begin
                n_cmp++; if (ctrl_if.reg_dst !== 1'b1 || ctrl_if.reg_write !== 1'b1) begin
                    n_bad++; $display("FAIL aluwb: got dst=%b rw=%b want 1 1",
                                      ctrl_if.reg_dst, ctrl_if.reg_write); end
            end
            if (i == 6) begin
                n_cmp++; if (ctrl_if.alu_op !== 3'b000 || ctrl_if.alu_src_b !== 2'b10) begin
                    n_bad++; $display("FAIL iexec: got op=%b srcb=%b want 000 10",
                                      ctrl_if.alu_op, ctrl_if.alu_src_b); end
            end
            if (i == 7) begin
                n_cmp++; if (ctrl_if.reg_dst !== 1'b0 || ctrl_if.reg_write !== 1'b1) begin
                    n_bad++; $display("FAIL iwb: got dst=%b rw=%b want 0 1",
                                      ctrl_if.reg_dst, ctrl_if.reg_write); end
            end
            tick();
        end
        exp_ret += 2;
        n_cmp++; if (ctrl_if.retired !== 4'(exp_ret)) begin n_bad++;
            $display("FAIL ri_retired: got %0d want %0d", ctrl_if.retired, exp_ret); end
    endtask

    task automatic test_sw_stall();
        ctrl_if.opcode = 6'b101011;
        repeat (3) tick();
        ctrl_if.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ctrl_if.mem_ready = 1'b1;
            n_cmp++; if (ctrl_if.state !== 4'd5 || ctrl_if.mem_write !== 1'b1) begin n_bad++;
                $display("FAIL sw_wait[%0d]: got st=%0d mw=%b want 5 1", i, ctrl_if.state,
                         ctrl_if.mem_write); end
            tick();
        end
        exp_ret++;
        n_cmp++; if (ctrl_if.state !== 4'd0 || ctrl_if.retired !== 4'(exp_ret)) begin n_bad++;
            $display("FAIL sw_end: got st=%0d ret=%0d want 0 %0d", ctrl_if.state,
                     ctrl_if.retired, exp_ret); end
        ctrl_if.mem_ready = 1'b0;
        #1;
        n_cmp++; if (ctrl_if.ir_write !== 1'b0 || ctrl_if.pc_write !== 1'b0) begin n_bad++;
            $display("FAIL fetch_stall: got irw=%b pcw=%b want 0 0", ctrl_if.ir_write,
                     ctrl_if.pc_write); end
        tick();
        n_cmp++; if (ctrl_if.state !== 4'd0) begin n_bad++;
            $display("FAIL fetch_hold: got %0d want 0", ctrl_if.state); end
        ctrl_if.mem_ready = 1'b1;
        #1;
        n_cmp++; if (ctrl_if.ir_write !== 1'b1 || ctrl_if.pc_write !== 1'b1) begin n_bad++;
            $display("FAIL fetch_go: got irw=%b pcw=%b want 1 1", ctrl_if.ir_write,
                     ctrl_if.pc_write); end
    endtask

    task automatic test_illegal_beq();
        ctrl_if.opcode = 6'b111111;
        tick();
        n_cmp++; if (ctrl_if.state !== 4'd1 || ctrl_if.illegal !== 1'b0) begin n_bad++;
            $display("FAIL ill_decode: got st=%0d ill=%b want 1 0", ctrl_if.state,
                     ctrl_if.illegal); end
        tick();
        ctrl_if.mem_ready = 1'b0;
        n_cmp++; if (ctrl_if.state !== 4'd0 || ctrl_if.illegal !== 1'b1 ||
                     ctrl_if.retired !== 4'(exp_ret)) begin n_bad++;
            $display("FAIL ill_pulse: got st=%0d ill=%b ret=%0d want 0 1 %0d", ctrl_if.state,
                     ctrl_if.illegal, ctrl_if.retired, exp_ret); end
        tick();
        n_cmp++; if (ctrl_if.illegal !== 1'b0) begin n_bad++;
            $display("FAIL ill_clear: got %b want 0", ctrl_if.illegal); end
        ctrl_if.mem_ready = 1'b1;
        ctrl_if.opcode = 6'b000100;
        repeat (2) tick();
        n_cmp++; if (ctrl_if.state !== 4'd8 || ctrl_if.alu_op !== 3'b001 ||
                     ctrl_if.branch_eq !== 1'b1 || ctrl_if.branch_ne !== 1'b0 ||
                     ctrl_if.pc_src !== 2'b01) begin n_bad++;
            $display("FAIL beq: got st=%0d op=%b beq=%b bne=%b src=%b want 8 001 1 0 01",
                     ctrl_if.state, ctrl_if.alu_op, ctrl_if.branch_eq, ctrl_if.branch_ne,
                     ctrl_if.pc_src); end
        tick();
        exp_ret++;
        n_cmp++; if (ctrl_if.branch_eq !== 1'b0 || ctrl_if.retired !== 4'(exp_ret)) begin
            n_bad++; $display("FAIL beq_end: got beq=%b ret=%0d want 0 %0d",
                              ctrl_if.branch_eq, ctrl_if.retired, exp_ret); end
    endtask

    task automatic test_reset_in_memrd();
        ctrl_if.opcode = 6'b100011;
        repeat (3) tick();
        ctrl_if.mem_ready = 1'b0;
        #1;
        n_cmp++; if (ctrl_if.state !== 4'd3 || ctrl_if.reg_write !== 1'b0) begin n_bad++;
            $display("FAIL memrd_stall: got st=%0d rw=%b want 3 0", ctrl_if.state,
                     ctrl_if.reg_write); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_ret = 0;
        n_cmp++; if (ctrl_if.state !== 4'd0 || ctrl_if.reg_write !== 1'b0 ||
                     ctrl_if.retired !== 4'd0) begin n_bad++;
            $display("FAIL memrd_reset: got st=%0d rw=%b ret=%0d want 0 0 0", ctrl_if.state,
                     ctrl_if.reg_write, ctrl_if.retired); end
        ctrl_if.mem_ready = 1'b1;
    endtask

    task automatic test_jump_wrap();
        ctrl_if.opcode = 6'b000010;
        for (int k = 0; k < 16; k++) begin
            repeat (2) tick();
            if (k == 0) begin
                n_cmp++; if (ctrl_if.state !== 4'd11 || ctrl_if.pc_write !== 1'b1 ||
                             ctrl_if.pc_src !== 2'b10) begin n_bad++;
                    $display("FAIL jump: got st=%0d pcw=%b src=%b want 11 1 10",
                             ctrl_if.state, ctrl_if.pc_write, ctrl_if.pc_src); end
            end
            tick();
            if (k == 14) begin
                n_cmp++; if (ctrl_if.retired !== 4'hf) begin n_bad++;
                    $display("FAIL ret_full: got %0d want 15", ctrl_if.retired); end
            end
        end
        n_cmp++; if (ctrl_if.retired !== 4'd0 || ctrl_if.state !== 4'd0) begin n_bad++;
            $display("FAIL ret_wrap: got ret=%0d st=%0d want 0 0", ctrl_if.retired,
                     ctrl_if.state); end
    endtask

    initial begin
        ctrl_if.opcode    = 6'b000000;
        ctrl_if.mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_rtype_addi();
        test_sw_stall();
        test_illegal_beq();
        test_reset_in_memrd();
        test_jump_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
